sprite_layer_arbiter: RTL and testbench

- Per-pixel arbiter between one background colour and NUM_SPRITES rectangular sprite layers; produces the 12-bit colour fed to the VGA timing block's red_in/gre_in/blu_in.
- Game logic writes sprite configuration into shadow registers. A commit handshake transfers all shadows to the active set atomically at the next frame boundary (vsync rising edge), so no frame ever tears.

---
 rtl/sprite_layer_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_sprite_layer_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_arbiter.sv
// Per-pixel arbiter between a background colour and NUM_SPRITES rectangular sprites.
// Sprite config is double-buffered; a commit copies shadow to active at the next vsync rising edge.
module sprite_layer_arbiter #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned SPRITE_H    = 32,
    parameter logic [11:0] BG_RESET    = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] curr_x,
    input  logic [9:0]  curr_y,
    input  logic        vsync,
    input  logic        wr_en,
    input  logic [1:0]  wr_slot,
    input  logic [10:0] wr_x,
    input  logic [9:0]  wr_y,
    input  logic [11:0] wr_colour,
    input  logic        wr_vis,
    input  logic        bg_wr,
    input  logic [11:0] bg_colour,
    input  logic        commit,
    output logic        commit_ack,
    output logic        busy,
    output logic [3:0]  red_out,
    output logic [3:0]  gre_out,
    output logic [3:0]  blu_out,
    output logic [2:0]  hit_slot,
    output logic [15:0] frame_cnt
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned CW = 12;
    localparam int          NS = int'(NUM_SPRITES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t state, state_next;
    logic   copy_c;
    logic   vsync_q;
    logic   boundary_c;

    logic [XW-1:0] sh_x   [NUM_SPRITES];
    logic [YW-1:0] sh_y   [NUM_SPRITES];
    logic [CW-1:0] sh_col [NUM_SPRITES];
    logic          sh_vis [NUM_SPRITES];
    logic [CW-1:0] sh_bg;

    logic [XW-1:0] act_x   [NUM_SPRITES];
    logic [YW-1:0] act_y   [NUM_SPRITES];
    logic [CW-1:0] act_col [NUM_SPRITES];
    logic          act_vis [NUM_SPRITES];
    logic [CW-1:0] act_bg;

    logic [NUM_SPRITES-1:0] hit_c;
    logic [NUM_SPRITES-1:0] s1_hit;
    logic [CW-1:0]          s1_col [NUM_SPRITES];
    logic [CW-1:0]          s1_bg;
    logic [CW-1:0]          sel_col_c;
    logic [2:0]             sel_slot_c;

    assign boundary_c = vsync & ~vsync_q;

    // Frame boundary detection and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            vsync_q <= vsync;
            if (boundary_c) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Commit FSM state register; busy/ack are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next == PENDING);
            commit_ack <= (state_next == ACK);
        end
    end

    // Commit FSM next state; a commit seen alongside a boundary in IDLE waits a full frame
    always_comb begin
        state_next = state;
        copy_c     = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (boundary_c) begin
                    copy_c     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shadow registers, writable at any time
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_col[i] <= '0;
                sh_vis[i] <= 1'b0;
            end
            sh_bg <= BG_RESET;
        end else begin
            if (wr_en && (32'(wr_slot) < NUM_SPRITES)) begin
                sh_x[wr_slot]   <= wr_x;
                sh_y[wr_slot]   <= wr_y;
                sh_col[wr_slot] <= wr_colour;
                sh_vis[wr_slot] <= wr_vis;
            end
            if (bg_wr) begin
                sh_bg <= bg_colour;
            end
        end
    end

    // Active registers; the copy sees the shadow value from before any same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                act_x[i]   <= '0;
                act_y[i]   <= '0;
                act_col[i] <= '0;
                act_vis[i] <= 1'b0;
            end
            act_bg <= BG_RESET;
        end else if (copy_c) begin
            for (int i = 0; i < NS; i++) begin
                act_x[i]   <= sh_x[i];
                act_y[i]   <= sh_y[i];
                act_col[i] <= sh_col[i];
                act_vis[i] <= sh_vis[i];
            end
            act_bg <= sh_bg;
        end
    end

    // Stage 1 hit test; right/bottom edges are one bit wider so off-screen sprites clip
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NS; i++) begin
            hit_c[i] = act_vis[i]
                    && (curr_x >= act_x[i])
                    && ({1'b0, curr_x} < ({1'b0, act_x[i]} + 12'(SPRITE_W)))
                    && (curr_y >= act_y[i])
                    && ({1'b0, curr_y} < ({1'b0, act_y[i]} + 11'(SPRITE_H)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit <= '0;
            for (int i = 0; i < NS; i++) begin
                s1_col[i] <= '0;
            end
            s1_bg <= BG_RESET;
        end else begin
            s1_hit <= hit_c;
            for (int i = 0; i < NS; i++) begin
                s1_col[i] <= act_col[i];
            end
            s1_bg <= act_bg;
        end
    end

    // Stage 2 fixed priority: lowest slot index wins
    always_comb begin
        sel_col_c  = s1_bg;
        sel_slot_c = 3'd7;
        for (int i = NS - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                sel_col_c  = s1_col[i];
                sel_slot_c = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_out  <= BG_RESET[11:8];
            gre_out  <= BG_RESET[7:4];
            blu_out  <= BG_RESET[3:0];
            hit_slot <= 3'd7;
        end else begin
            red_out  <= sel_col_c[11:8];
            gre_out  <= sel_col_c[7:4];
            blu_out  <= sel_col_c[3:0];
            hit_slot <= sel_slot_c;
        end
    end

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Scoreboard bench for sprite_layer_arbiter: a frame-level reference model predicts
// control outputs and arbitrated pixels; a negedge monitor compares them.
module tb_sprite_layer_arbiter;

    localparam int          NUM = 4;
    localparam int          SW  = 32;
    localparam int          SH  = 32;
    localparam logic [11:0] BG  = 12'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] curr_x = '0;
    logic [9:0]  curr_y = '0;
    logic        vsync = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_slot = '0;
    logic [10:0] wr_x = '0;
    logic [9:0]  wr_y = '0;
    logic [11:0] wr_colour = '0;
    logic        wr_vis = 1'b0;
    logic        bg_wr = 1'b0;
    logic [11:0] bg_colour = '0;
    logic        commit = 1'b0;
    logic        commit_ack;
    logic        busy;
    logic [3:0]  red_out, gre_out, blu_out;
    logic [2:0]  hit_slot;
    logic [15:0] frame_cnt;

    sprite_layer_arbiter #(
        .NUM_SPRITES(NUM), .SPRITE_W(SW), .SPRITE_H(SH), .BG_RESET(BG)
    ) dut (
        .clk(clk), .rst(rst), .curr_x(curr_x), .curr_y(curr_y), .vsync(vsync),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y),
        .wr_colour(wr_colour), .wr_vis(wr_vis), .bg_wr(bg_wr), .bg_colour(bg_colour),
        .commit(commit), .commit_ack(commit_ack), .busy(busy),
        .red_out(red_out), .gre_out(gre_out), .blu_out(blu_out),
        .hit_slot(hit_slot), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] col;
        logic [2:0]  slot;
    } pix_t;

    typedef struct {
        int          due;
        logic        busy;
        logic        ack;
        logic [15:0] fc;
    } ctrl_t;

    pix_t  pq[$];
    ctrl_t cq[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sprite configs as plain integers plus commit bookkeeping
    int          m_sx[NUM], m_sy[NUM], m_ax[NUM], m_ay[NUM];
    logic [11:0] m_scol[NUM], m_acol[NUM];
    bit          m_svis[NUM], m_avis[NUM];
    logic [11:0] m_sbg, m_abg;
    bit          m_pending, m_ack, m_vq;
    logic [15:0] m_fc;

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_scol[i] = 0; m_svis[i] = 0;
            m_ax[i] = 0; m_ay[i] = 0; m_acol[i] = 0; m_avis[i] = 0;
        end
        m_sbg = BG; m_abg = BG;
        m_pending = 0; m_ack = 0; m_vq = 0; m_fc = 0;
    endtask

    function automatic void ref_pixel(input int x, input int y,
                                      output logic [11:0] c, output logic [2:0] s);
        bit found = 0;
        c = m_abg;
        s = 3'd7;
        for (int i = 0; i < NUM; i++) begin
            if (!found && m_avis[i] && x >= m_ax[i] && x < m_ax[i] + SW
                && y >= m_ay[i] && y < m_ay[i] + SH) begin
                found = 1;
                c = m_acol[i];
                s = 3'(i);
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: predict, advance the model across the edge, then wait for the edge
    task automatic tick();
        pix_t  p;
        ctrl_t c;
        bit    boundary;
        bit    nxt_pending, nxt_ack;
        ref_pixel(int'(curr_x), int'(curr_y), p.col, p.slot);
        p.due = cyc + 2;
        if (rst) begin
            pix_t prev;
            p.col = BG;
            p.slot = 3'd7;
            if (pq.size() > 0 && pq[pq.size()-1].due == cyc + 1) begin
                prev = pq.pop_back();
                prev.col = BG;
                prev.slot = 3'd7;
                pq.push_back(prev);
            end
            model_reset();
        end else begin
            boundary = vsync && !m_vq;
            m_vq = vsync;
            if (boundary) m_fc = m_fc + 16'd1;
            nxt_ack     = m_pending && boundary;
            nxt_pending = (m_pending && !boundary) || (!m_pending && !m_ack && commit);
            if (nxt_ack) begin
                for (int i = 0; i < NUM; i++) begin
                    m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i];
                    m_acol[i] = m_scol[i]; m_avis[i] = m_svis[i];
                end
                m_abg = m_sbg;
            end
            m_pending = nxt_pending;
            m_ack = nxt_ack;
            if (wr_en && int'(wr_slot) < NUM) begin
                m_sx[wr_slot] = int'(wr_x); m_sy[wr_slot] = int'(wr_y);
                m_scol[wr_slot] = wr_colour; m_svis[wr_slot] = wr_vis;
            end
            if (bg_wr) m_sbg = bg_colour;
        end
        pq.push_back(p);
        c.due = cyc + 1;
        c.busy = m_pending;
        c.ack = m_ack;
        c.fc = m_fc;
        cq.push_back(c);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare whatever the scoreboard expects for this cycle
    always @(negedge clk) begin
        if (cq.size() > 0 && cq[0].due == cyc) begin
            ctrl_t e;
            e = cq.pop_front();
            check("busy", int'(busy), int'(e.busy));
            check("commit_ack", int'(commit_ack), int'(e.ack));
            check("frame_cnt", int'(frame_cnt), int'(e.fc));
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            pix_t e;
            e = pq.pop_front();
            check("colour", int'({red_out, gre_out, blu_out}), int'(e.col));
            check("hit_slot", int'(hit_slot), int'(e.slot));
        end
    end

    task automatic write_slot(input int s, input int x, input int y,
                              input logic [11:0] col, input bit vis);
        wr_en = 1; wr_slot = 2'(s); wr_x = 11'(x); wr_y = 10'(y);
        wr_colour = col; wr_vis = vis;
        tick();
        wr_en = 0;
    endtask

    task automatic do_commit();
        commit = 1;
        tick();
        commit = 0;
    endtask

    task automatic vsync_pulse();
        vsync = 1;
        repeat (3) tick();
        vsync = 0;
        repeat (3) tick();
    endtask

    task automatic pix(input int x, input int y);
        curr_x = 11'(x);
        curr_y = 10'(y);
        tick();
    endtask

    initial begin
        int x, y, s;
        model_reset();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        pix(0, 0); pix(1439, 899); pix(100, 50);

        // Single sprite, commit, one frame boundary
        write_slot(1, 100, 50, 12'hF00, 1);
        do_commit();
        repeat (4) tick();
        vsync_pulse();
        pix(100, 50); pix(131, 81); pix(132, 50); pix(99, 50); pix(100, 82);

        // Overlap: slot 0 beats slot 1
        write_slot(0, 100, 50, 12'h0F0, 1);
        write_slot(1, 110, 60, 12'hF00, 1);
        do_commit();
        vsync_pulse();
        pix(115, 65); pix(105, 55); pix(140, 90);

        // Shadow write without commit across three frames
        write_slot(2, 300, 300, 12'h00F, 1);
        bg_wr = 1; bg_colour = 12'h123; tick(); bg_wr = 0;
        repeat (3) vsync_pulse();
        pix(310, 310); pix(0, 0);

        // Corner sprite; commit coincides with the boundary so it lands a frame later
        write_slot(3, 1430, 890, 12'hABC, 1);
        commit = 1; vsync = 1; tick();
        commit = 0; tick(); tick();
        vsync = 0; repeat (3) tick();
        pix(1439, 899); pix(310, 310);
        vsync_pulse();
        pix(1439, 899); pix(1430, 890); pix(0, 0); pix(5, 5); pix(310, 310); pix(1429, 899);

        // Reset while pending drops the commit
        write_slot(0, 200, 200, 12'hFFF, 1);
        do_commit();
        repeat (2) tick();
        rst = 1; tick(); rst = 0;
        repeat (2) tick();
        vsync_pulse();
        pix(205, 205); pix(1439, 899);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            wr_en     = ($urandom % 6) == 0;
            wr_slot   = 2'($urandom);
            wr_x      = 11'($urandom_range(0, 1439));
            wr_y      = 10'($urandom_range(0, 899));
            wr_colour = 12'($urandom);
            wr_vis    = ($urandom % 4) != 0;
            bg_wr     = ($urandom % 20) == 0;
            bg_colour = 12'($urandom);
            commit    = ($urandom % 25) == 0;
            vsync     = (i % 150) < 4;
            rst       = ($urandom % 700) == 0;
            if ($urandom % 3 == 0) begin
                x = $urandom_range(0, 1439);
                y = $urandom_range(0, 899);
            end else begin
                s = $urandom_range(0, NUM - 1);
                x = m_ax[s] + $urandom_range(0, 40) - 4;
                y = m_ay[s] + $urandom_range(0, 40) - 4;
                if (x < 0) x = 0;
                if (x > 1439) x = 1439;
                if (y < 0) y = 0;
                if (y > 899) y = 899;
            end
            curr_x = 11'(x);
            curr_y = 10'(y);
            tick();
        end
        wr_en = 0; bg_wr = 0; commit = 0; vsync = 0; rst = 0;

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", pq.size() + cq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
